// File: rtl/axis_1553_encoder.sv
// MIL-STD-1553 Manchester II transmitter: one AXI-Stream word becomes sync + 16 data bits
// + odd parity on a differential pair, followed by a forced idle gap.
module axis_1553_encoder #(
   parameter int clock_speed = 20000000,
   parameter int gap_bits    = 4,
   parameter bit invert_data = 1'b0
) (
   input  logic        aclk,
   input  logic        arstn,
   input  logic [15:0] s_axis_tdata,
   input  logic [7:0]  s_axis_tuser,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   output logic [1:0]  diff,
   output logic        busy
);

   function automatic int clogb2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction

   localparam int HALF    = clock_speed / 2000000;
   localparam int BIT     = 2 * HALF;
   localparam int GAP_CYC = gap_bits * BIT;
   localparam int HALF_W  = clogb2(HALF);
   localparam int GAP_W   = clogb2(GAP_CYC);

   typedef enum logic [2:0] {IDLE, SYNC, DATA, PARITY, GAP} state_t;

   state_t              state_q, state_d;
   logic [HALF_W-1:0]   half_cnt_q, half_cnt_d;
   logic [2:0]          phase_q, phase_d;
   logic [3:0]          bit_idx_q, bit_idx_d;
   logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
   logic [15:0]         data_q, data_d;
   logic                cmd_q, cmd_d;
   logic                par_q, par_d;
   logic                tready_q, tready_d;
   logic [1:0]          diff_q, diff_d;
   logic                busy_q, busy_d;

   logic                half_last;
   logic                cur_bit;
   logic                unused_tuser;

   assign unused_tuser = ^s_axis_tuser[4:1];

   // diff[0] carries the line level; the pair is complemented, optionally swapped.
   function automatic logic [1:0] drive(input logic level);
      return invert_data ? {level, ~level} : {~level, level};
   endfunction

   always_comb begin
      state_d    = state_q;
      half_cnt_d = half_cnt_q;
      phase_d    = phase_q;
      bit_idx_d  = bit_idx_q;
      gap_cnt_d  = gap_cnt_q;
      data_d     = data_q;
      cmd_d      = cmd_q;
      par_d      = par_q;
      tready_d   = tready_q;
      busy_d     = busy_q;
      diff_d     = 2'b00;
      half_last  = (half_cnt_q == HALF_W'(HALF - 1));
      cur_bit    = data_q[bit_idx_q];

      unique case (state_q)
         IDLE: begin
            half_cnt_d = '0;
            phase_d    = 3'd0;
            tready_d   = 1'b1;
            if (s_axis_tvalid && tready_q) begin
               data_d   = s_axis_tdata;
               cmd_d    = (s_axis_tuser[7:5] == 3'b100);
               par_d    = (~^s_axis_tdata) ^ s_axis_tuser[0];
               tready_d = 1'b0;
               busy_d   = 1'b1;
               state_d  = SYNC;
            end
         end
         SYNC: begin
            // Six half-bit periods: three at the sync polarity, three at its inverse.
            diff_d     = drive((phase_q < 3'd3) ? cmd_q : ~cmd_q);
            half_cnt_d = half_last ? '0 : half_cnt_q + HALF_W'(1);
            if (half_last) begin
               phase_d = phase_q + 3'd1;
               if (phase_q == 3'd5) begin
                  phase_d   = 3'd0;
                  bit_idx_d = 4'd15;
                  state_d   = DATA;
               end
            end
         end
         DATA: begin
            diff_d     = drive(phase_q[0] ? ~cur_bit : cur_bit);
            half_cnt_d = half_last ? '0 : half_cnt_q + HALF_W'(1);
            if (half_last) begin
               phase_d = {2'b00, ~phase_q[0]};
               if (phase_q[0]) begin
                  if (bit_idx_q == 4'd0) state_d = PARITY;
                  else                   bit_idx_d = bit_idx_q - 4'd1;
               end
            end
         end
         PARITY: begin
            diff_d     = drive(phase_q[0] ? ~par_q : par_q);
            half_cnt_d = half_last ? '0 : half_cnt_q + HALF_W'(1);
            if (half_last) begin
               phase_d = {2'b00, ~phase_q[0]};
               if (phase_q[0]) begin
                  gap_cnt_d = '0;
                  state_d   = GAP;
               end
            end
         end
         GAP: begin
            // tready rises with the IDLE entry so the next word can go on the following edge.
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
            if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
               tready_d = 1'b1;
               busy_d   = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!arstn) begin
         state_q    <= IDLE;
         half_cnt_q <= '0;
         phase_q    <= 3'd0;
         bit_idx_q  <= 4'd15;
         gap_cnt_q  <= '0;
         data_q     <= 16'h0000;
         cmd_q      <= 1'b0;
         par_q      <= 1'b0;
         tready_q   <= 1'b0;
         diff_q     <= 2'b00;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         half_cnt_q <= half_cnt_d;
         phase_q    <= phase_d;
         bit_idx_q  <= bit_idx_d;
         gap_cnt_q  <= gap_cnt_d;
         data_q     <= data_d;
         cmd_q      <= cmd_d;
         par_q      <= par_d;
         tready_q   <= tready_d;
         diff_q     <= diff_d;
         busy_q     <= busy_d;
      end
   end

   assign s_axis_tready = tready_q;
   assign diff          = diff_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_axis_1553_encoder.sv
// Bench for axis_1553_encoder: table of words plus random words, decoded from diff and
// compared against a scoreboard; hand sequences cover reset, latency and mid-word reset.
`timescale 1ns/1ps
module tb_axis_1553_encoder;
   localparam int CLK_HZ      = 20000000;
   localparam int GAP_BITS    = 4;
   localparam int HALF        = CLK_HZ / 2000000;
   localparam int BIT         = 2 * HALF;
   localparam int WORD_CYC    = 20 * BIT;
   localparam int ACC_SPACING = WORD_CYC + GAP_BITS * BIT + 1;
   localparam int IDLE_RUN    = GAP_BITS * BIT + 1;

   logic        aclk = 1'b0;
   logic        arstn = 1'b0;
   logic [15:0] s_axis_tdata = 16'h0000;
   logic [7:0]  s_axis_tuser = 8'h00;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic [1:0]  diff;
   logic        busy;

   typedef struct {
      logic [15:0] tdata;
      logic        cmd;
      logic        par;
      logic        err;
   } exp_t;

   typedef struct {
      logic [15:0] tdata;
      logic [7:0]  tuser;
      logic        exp_cmd;
      logic        exp_par;
   } vec_t;

   exp_t sb[$];
   vec_t vt[7];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   bit   cap[0:511];
   int   cap_n = 0;
   int   comp_err = 0;
   int   idle_run = 0;
   bit   in_word = 1'b0;
   bit   abort = 1'b0;
   bit   have_prev = 1'b0;
   bit   send_prev = 1'b0;
   int   last_acc = 0;

   axis_1553_encoder #(
      .clock_speed(CLK_HZ),
      .gap_bits   (GAP_BITS),
      .invert_data(1'b0)
   ) dut (
      .aclk         (aclk),
      .arstn        (arstn),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tuser (s_axis_tuser),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .diff         (diff),
      .busy         (busy)
   );

   always #25 aclk = ~aclk;
   always @(posedge aclk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic analyze();
      exp_t        e;
      logic [15:0] d;
      logic        c, p, v, perr;
      bit          shape_ok;
      if (abort) begin
         have_prev = 1'b0;
         return;
      end
      if (sb.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL unexpected_word: word of %0d cycles with empty scoreboard", cap_n);
         return;
      end
      e = sb.pop_front();
      shape_ok = 1'b1;
      c = cap[0];
      for (int i = 0; i < 3 * HALF; i++)
         if (cap[i] != c || cap[i + 3 * HALF] != ~c) shape_ok = 1'b0;
      d = 16'h0000;
      p = 1'b0;
      for (int b = 0; b < 17; b++) begin
         v = cap[6 * HALF + b * BIT];
         for (int k = 0; k < HALF; k++)
            if (cap[6 * HALF + b * BIT + k] != v || cap[6 * HALF + b * BIT + HALF + k] != ~v)
               shape_ok = 1'b0;
         if (b < 16) d[15 - b] = v;
         else        p = v;
      end
      perr = ~(^{d, p});
      chk("word_len", cap_n, WORD_CYC);
      chk("diff_complement", comp_err, 0);
      chk("manchester_shape", {31'd0, shape_ok}, 1);
      chk("sync_type", {31'd0, c}, {31'd0, e.cmd});
      chk("tdata", {16'd0, d}, {16'd0, e.tdata});
      chk("parity_bit", {31'd0, p}, {31'd0, e.par});
      chk("parity_err_flag", {31'd0, perr}, {31'd0, e.err});
      have_prev = 1'b1;
   endtask

   // Line monitor: captures diff[0] for each driven burst and decodes it.
   initial begin
      @(posedge aclk);
      forever begin
         @(negedge aclk);
         if (diff !== 2'b00) begin
            if (!in_word) begin
               if (have_prev) chk("gap_len", idle_run, IDLE_RUN);
               in_word = 1'b1;
               cap_n = 0;
               comp_err = 0;
            end
            if (cap_n < 512) cap[cap_n] = diff[0];
            cap_n++;
            if (diff[1] === diff[0]) comp_err++;
            idle_run = 0;
         end else begin
            idle_run++;
            if (in_word) begin
               in_word = 1'b0;
               analyze();
            end
         end
      end
   end

   // Called at a negedge; returns two negedges after the accepting edge.
   task automatic send(input logic [15:0] d, input logic [7:0] u, input logic c, input logic p);
      int   n;
      exp_t e;
      s_axis_tdata  = d;
      s_axis_tuser  = u;
      s_axis_tvalid = 1'b1;
      n = 0;
      while (s_axis_tready !== 1'b1 && n < 4 * ACC_SPACING) begin
         @(negedge aclk);
         n++;
      end
      if (s_axis_tready !== 1'b1) begin
         n_chk++;
         n_fail++;
         $display("FAIL accept_timeout: tready %b after %0d cycles, required 1", s_axis_tready, n);
         s_axis_tvalid = 1'b0;
         return;
      end
      if (send_prev) chk("accept_spacing", cyc - last_acc, ACC_SPACING);
      last_acc  = cyc;
      send_prev = 1'b1;
      e.tdata = d;
      e.cmd   = c;
      e.par   = p;
      e.err   = u[0];
      sb.push_back(e);
      @(negedge aclk);
      chk("tready_drop", {31'd0, s_axis_tready}, 0);
      chk("busy_rise", {31'd0, busy}, 1);
      chk("diff_at_accept", {30'd0, diff}, 0);
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = 16'($urandom);
      s_axis_tuser  = 8'($urandom);
      @(negedge aclk);
      chk("first_sync_level", {30'd0, diff}, c ? 32'd1 : 32'd2);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy !== 1'b0 || sb.size() != 0) && n < 2 * ACC_SPACING) begin
         @(negedge aclk);
         n++;
      end
      chk("drain_scoreboard", sb.size(), 0);
      @(negedge aclk);
      chk("idle_busy", {31'd0, busy}, 0);
      chk("idle_tready", {31'd0, s_axis_tready}, 1);
   endtask

   initial begin
      #5_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      logic [15:0] rd;
      logic [7:0]  ru;
      vt[0] = '{16'hA5A5, 8'h80, 1'b1, 1'b1};
      vt[1] = '{16'h0001, 8'h40, 1'b0, 1'b0};
      vt[2] = '{16'h0000, 8'h41, 1'b0, 1'b0};
      vt[3] = '{16'hFFFF, 8'h9F, 1'b1, 1'b0};
      vt[4] = '{16'h8000, 8'hE0, 1'b0, 1'b0};
      vt[5] = '{16'h7FFE, 8'h00, 1'b0, 1'b1};
      vt[6] = '{16'h1234, 8'h80, 1'b1, 1'b0};

      repeat (4) @(negedge aclk);
      chk("rst_tready", {31'd0, s_axis_tready}, 0);
      chk("rst_diff", {30'd0, diff}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      arstn = 1'b1;
      @(negedge aclk);
      chk("tready_after_release", {31'd0, s_axis_tready}, 1);
      chk("diff_after_release", {30'd0, diff}, 0);

      // Table words then random words, sent back to back.
      send_prev = 1'b0;
      have_prev = 1'b0;
      foreach (vt[i]) send(vt[i].tdata, vt[i].tuser, vt[i].exp_cmd, vt[i].exp_par);
      for (int i = 0; i < 40; i++) begin
         rd = 16'($urandom);
         ru = 8'($urandom);
         send(rd, ru, ru[7:5] == 3'b100, (~^rd) ^ ru[0]);
      end
      wait_idle();

      // Reset in the middle of data bit 8.
      send_prev = 1'b0;
      have_prev = 1'b0;
      send(16'hC3C3, 8'h81, 1'b1, 1'b0);
      repeat (6 * HALF + 8 * BIT + 2) @(negedge aclk);
      abort = 1'b1;
      arstn = 1'b0;
      @(negedge aclk);
      chk("abort_diff", {30'd0, diff}, 0);
      chk("abort_tready", {31'd0, s_axis_tready}, 0);
      chk("abort_busy", {31'd0, busy}, 0);
      if (sb.size() != 0) void'(sb.pop_front());
      repeat (2) @(negedge aclk);
      abort = 1'b0;
      arstn = 1'b1;
      @(negedge aclk);
      chk("abort_tready_release", {31'd0, s_axis_tready}, 1);
      have_prev = 1'b0;
      send_prev = 1'b0;
      send(16'h5A3C, 8'h80, 1'b1, 1'b1);
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
